mantissa_reciprocal_nr: RTL and testbench

// Initiator side of the mantissa reciprocal LUT interface: accepts a 24-bit

---
 rtl/mantissa_reciprocal_nr.sv | 76 +++++++
 tb/tb_mantissa_reciprocal_nr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_reciprocal_nr.sv
// mantissa_reciprocal_nr: LUT-seeded Newton-Raphson reciprocal of a Q1.23 mantissa, Q0.24 result
module mantissa_reciprocal_nr #(
    parameter int ITERATIONS  = 2,
    parameter int LUT_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_mant,
    output logic [7:0]  lut_in,
    input  logic [23:0] lut_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_recip
);
    typedef enum logic [2:0] {IDLE, WAIT, MUL_E, MUL_X, DONE} state_t;
    state_t state, state_nx;
    logic [23:0] d, x;
    logic [24:0] t, mul_a;
    logic [48:0] prod;
    logic [7:0]  cnt;
    logic [1:0]  iter;
    logic        lut_hit, last_iter;
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign out_recip = x;
    assign lut_hit   = (cnt == 8'(LUT_LATENCY));
    assign last_iter = (iter == 2'(ITERATIONS - 1));
    // A single multiplier: d*x in MUL_E, x*t in MUL_X.
    assign mul_a = (state == MUL_X) ? t : {1'b0, d};
    assign prod  = 49'(mul_a) * 49'(x);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (in_valid && in_ready) ? WAIT : IDLE;
            WAIT:    state_nx = lut_hit ? ((ITERATIONS == 0) ? DONE : MUL_E) : WAIT;
            MUL_E:   state_nx = MUL_X;
            MUL_X:   state_nx = last_iter ? DONE : MUL_E;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lut_in <= 8'h00;
            d      <= 24'h0;
            x      <= 24'h0;
            t      <= 25'h0;
            cnt    <= 8'h0;
            iter   <= 2'h0;
        end else begin
            state <= state_nx;
            if (in_valid && in_ready) begin
                d      <= in_mant;
                lut_in <= in_mant[22:15];
                cnt    <= 8'h0;
                iter   <= 2'h0;
            end
            if (state == WAIT) begin
                cnt <= cnt + 8'h1;
                if (lut_hit)
                    x <= lut_out;
            end
            // p[47:23] is d*x in Q1.24; 2.0 - p wraps to exactly -p in 25 bits.
            if (state == MUL_E)
                t <= ~prod[47:23] + 25'h1;
            // x*t is Q1.48; an integer bit means the result reached 1.0, so saturate.
            if (state == MUL_X) begin
                x    <= prod[48] ? 24'hFFFFFF : prod[47:24];
                iter <= iter + 2'h1;
            end
        end
    end
endmodule

// File: tb/tb_mantissa_reciprocal_nr.sv
// tb_mantissa_reciprocal_nr: directed checks of the NR reciprocal against a registered LUT model
module tb_mantissa_reciprocal_nr;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [23:0] in_mant = 0, lut_out = 0, out_recip;
    logic [7:0]  lut_in;
    logic        z_in_valid = 0, z_in_ready, z_out_valid, z_out_ready = 1;
    logic [23:0] z_in_mant = 0, z_lut_out = 0, z_out_recip;
    logic [7:0]  z_lut_in;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    mantissa_reciprocal_nr dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant),
        .lut_in(lut_in), .lut_out(lut_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_recip(out_recip)
    );

    mantissa_reciprocal_nr #(.ITERATIONS(0), .LUT_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready), .in_mant(z_in_mant),
        .lut_in(z_lut_in), .lut_out(z_lut_out), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_recip(z_out_recip)
    );

    function automatic logic [23:0] seed(input logic [7:0] i);
        longint v;
        v = (64'd1 << 32) / (64'd256 + 64'(i));
        return (v > 64'hFFFFFF) ? 24'hFFFFFF : v[23:0];
    endfunction

    function automatic longint ideal(input logic [23:0] m);
        return (64'd1 << 47) / 64'(m);
    endfunction

    function automatic longint absdiff(input logic [23:0] a, input longint b);
        return (64'(a) > b) ? 64'(a) - b : b - 64'(a);
    endfunction

    always @(posedge clk) begin
        lut_out   <= seed(lut_in);
        z_lut_out <= seed(z_lut_in);
    end

    task automatic run_op(input logic [23:0] m, output logic [23:0] r, output int lat);
        in_mant  = m;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        r = out_recip;
        if (!out_valid) begin
            total++;
            $display("FAIL timeout mant=%h out_valid never rose", m);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_recip !== 24'h0 || lut_in !== 8'h0 || in_ready !== 1'b0)
            $display("FAIL reset_state valid=%b recip=%h lut_in=%h ready=%b need 0/0/0/0", out_valid, out_recip, lut_in, in_ready);
        else passed++;
        rst = 0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b need 1", in_ready);
        else passed++;
    endtask

    task automatic test_unity;
        logic [23:0] r;
        int lat;
        in_mant  = 24'h800000;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        total++;
        if (lut_in !== 8'h00) $display("FAIL unity_lut_in got %h need 00", lut_in);
        else passed++;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat != 6) $display("FAIL unity_latency got %0d need 6", lat);
        else passed++;
        total++;
        if (out_recip !== 24'hFFFFFF) $display("FAIL unity_value got %h need ffffff", out_recip);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_one_half;
        logic [23:0] r;
        int lat;
        run_op(24'hC00000, r, lat);
        total++;
        if (lut_in !== 8'h80) $display("FAIL half_lut_in got %h need 80", lut_in);
        else passed++;
        total++;
        if (absdiff(r, 64'hAAAAAA) > 4) $display("FAIL half_value got %h need aaaaaa+-4", r);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_max;
        logic [23:0] r;
        int lat;
        run_op(24'hFFFFFF, r, lat);
        total++;
        if (lut_in !== 8'hFF) $display("FAIL max_lut_in got %h need ff", lut_in);
        else passed++;
        total++;
        if (absdiff(r, 64'h800000) > 4) $display("FAIL max_value got %h need 800000+-4", r);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        logic [23:0] m, r;
        int lat;
        for (int i = 0; i < 256; i++) begin
            m = {1'b1, 8'(i), 15'($urandom_range(0, 32767))};
            run_op(m, r, lat);
            total++;
            if (absdiff(r, ideal(m)) > 4 || lat != 6)
                $display("FAIL sweep mant=%h got %h need %h+-4 lat=%0d need 6", m, r, ideal(m), lat);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [23:0] r;
        int lat;
        out_ready = 0;
        run_op(24'hA00000, r, lat);
        in_mant  = 24'hE12345;
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_recip !== r || in_ready !== 1'b0 || lut_in !== 8'h40)
                $display("FAIL hold_%0d valid=%b recip=%h ready=%b lut_in=%h need 1/%h/0/40", i, out_valid, out_recip, in_ready, lut_in, r);
            else passed++;
        end
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL release valid=%b ready=%b need 0/1", out_valid, in_ready);
        else passed++;
        total++;
        if (absdiff(r, ideal(24'hA00000)) > 4) $display("FAIL hold_value got %h need %h+-4", r, ideal(24'hA00000));
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic [23:0] r;
        int lat;
        in_mant  = 24'hC00000;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || lut_in !== 8'h00 || in_ready !== 1'b0)
            $display("FAIL midreset valid=%b lut_in=%h ready=%b need 0/00/0", out_valid, lut_in, in_ready);
        else passed++;
        rst = 0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL midreset_idle in_ready=%b need 1", in_ready);
        else passed++;
        run_op(24'hFFFFFF, r, lat);
        total++;
        if (absdiff(r, 64'h800000) > 4 || lat != 6)
            $display("FAIL midreset_next got %h need 800000+-4 lat=%0d need 6", r, lat);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_iter0;
        logic [23:0] vec [3] = '{24'h800000, 24'h9A3456, 24'hFF8001};
        int lat;
        for (int i = 0; i < 3; i++) begin
            z_in_mant  = vec[i];
            z_in_valid = 1;
            @(posedge clk); #1;
            z_in_valid = 0;
            lat = 0;
            while (!z_out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            total++;
            if (lat != 2 || z_out_recip !== seed(vec[i][22:15]))
                $display("FAIL iter0_%0d got %h lat=%0d need %h lat=2", i, z_out_recip, lat, seed(vec[i][22:15]));
            else passed++;
            @(posedge clk); #1;
            total++;
            if (z_out_valid !== 1'b0 || z_in_ready !== 1'b1)
                $display("FAIL iter0_ret_%0d valid=%b ready=%b need 0/1", i, z_out_valid, z_in_ready);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_unity;
        test_one_half;
        test_max;
        test_sweep;
        test_backpressure;
        test_reset_mid;
        test_iter0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
